// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if
// Groups the two requester handshakes, the shared read-data/busy status and the
// SRAM address/control pins of sram_access_arbiter. The bidirectional SRAM data
// bus is a plain inout port on the arbiter, so it does not appear here.
//   req_x/we_x/addr_x/data_x : requester x (a or b) command, level request
//   ack_x                    : one-cycle completion pulse for requester x
//   read_data, busy          : last read result, arbiter not idle
//   sram_addr, sram_*_n      : SRAM address and active-low CE/WE/OE
interface sram_access_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic              ack_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic              ack_b;

    logic [DATA_W-1:0] read_data;
    logic              busy;

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_we_n;
    logic              sram_oe_n;

    // Requesters and SRAM observers.
    modport master (
        output req_a, we_a, addr_a, data_a,
        output req_b, we_b, addr_b, data_b,
        input  ack_a, ack_b, read_data, busy,
        input  sram_addr, sram_ce_n, sram_we_n, sram_oe_n
    );

    // The arbiter itself.
    modport slave (
        input  req_a, we_a, addr_a, data_a,
        input  req_b, we_b, addr_b, data_b,
        output ack_a, ack_b, read_data, busy,
        output sram_addr, sram_ce_n, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
// Shares one asynchronous SRAM between two req/ack requesters with round-robin
// arbitration on ties, and generates SETUP / ACCESS (ACCESS_CYCLES) / HOLD timing.
// Ports:
//   clk       : system clock, all state on the rising edge
//   rst       : asynchronous active-high reset
//   bus       : handshake, status and SRAM address/control (slave modport)
//   sram_data : SRAM data bus, driven only during write transactions
// Every pin and ack is a flop, computed from the next state, so there is no
// combinational path from requester inputs to the SRAM.
module sram_access_arbiter #(
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_access_arbiter_if.slave bus,
    inout  wire  [DATA_W-1:0]    sram_data
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    // Counter runs ACCESS_CYCLES-1 down to 0, so a value of 1 gives one ACCESS cycle.
    localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ptr_q, ptr_d;          // 1: port B wins the next tie
    logic              grant_b_q, grant_b_d;  // port currently being served
    logic              sel_b;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              data_oe_q, data_oe_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_b_d = grant_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        sel_b     = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.req_a || bus.req_b) begin
                    sel_b     = bus.req_b && (!bus.req_a || ptr_q);
                    grant_b_d = sel_b;
                    ptr_d     = !sel_b;
                    we_d      = sel_b ? bus.we_b   : bus.we_a;
                    addr_d    = sel_b ? bus.addr_b : bus.addr_a;
                    wdata_d   = sel_b ? bus.data_b : bus.data_a;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = CntLoad;
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    // Last strobe cycle: the SRAM is still driving for a read.
                    if (!we_q) begin
                        rdata_d = sram_data;
                    end
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Pins for the coming cycle; we_d already reflects a fresh capture from IDLE.
        ce_n_d    = (state_d == StIdle);
        we_n_d    = !(we_d && (state_d == StAccess));
        oe_n_d    = !(!we_d && ((state_d == StSetup) || (state_d == StAccess)));
        data_oe_d = we_d && (state_d != StIdle);
        ack_a_d   = (state_d == StHold) && !grant_b_d;
        ack_b_d   = (state_d == StHold) && grant_b_d;
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            ptr_q     <= 1'b0;
            grant_b_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_b_q <= grant_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ce_n_q    <= ce_n_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            data_oe_q <= data_oe_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sram_addr = addr_q;
    assign bus.sram_ce_n = ce_n_q;
    assign bus.sram_we_n = we_n_q;
    assign bus.sram_oe_n = oe_n_q;
    assign bus.ack_a     = ack_a_q;
    assign bus.ack_b     = ack_b_q;
    assign bus.read_data = rdata_q;
    assign bus.busy      = busy_q;

    assign sram_data = data_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: main instance (ACCESS_CYCLES=2) with an SRAM
// model, plus two write-only instances for ACCESS_CYCLES=1 and 15.
module tb_sram_access_arbiter;

    logic clk;
    logic rst;
    logic mem_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_access_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus ();
    sram_access_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus1 ();
    sram_access_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus15 ();
    wire [7:0] sram_data;
    wire [7:0] sram_data1;
    wire [7:0] sram_data15;

    sram_access_arbiter #(.ADDR_W(19), .DATA_W(8), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sram_data(sram_data)
    );
    sram_access_arbiter #(.ADDR_W(19), .DATA_W(8), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sram_data(sram_data1)
    );
    sram_access_arbiter #(.ADDR_W(19), .DATA_W(8), .ACCESS_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .bus(bus15), .sram_data(sram_data15)
    );

    // SRAM model: drives on a read, commits a write when WE rises with CE still low.
    logic [7:0] mem [0:255];
    logic       lat_valid;
    logic [7:0] lat_addr;
    logic [7:0] lat_data;

    assign sram_data = (!bus.sram_ce_n && !bus.sram_oe_n && bus.sram_we_n)
                       ? mem[bus.sram_addr[7:0]] : 8'bz;

    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            lat_valid <= 1'b0;
        end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
            lat_valid <= 1'b1;
            lat_addr  <= bus.sram_addr[7:0];
            lat_data  <= sram_data;
        end else if (lat_valid) begin
            if (!bus.sram_ce_n) mem[lat_addr] <= lat_data;
            lat_valid <= 1'b0;
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle checks valid at any sample point of the main instance.
    task automatic cycle_checks();
        if (!bus.sram_oe_n) check("bus_contention", 32'(dut.data_oe_q), 32'd0);
        if (bus.ack_a || bus.ack_b) check("dual_ack", 32'(bus.ack_a && bus.ack_b), 32'd0);
    endtask

    // Called just after a rising edge with the arbiter idle; returns likewise.
    task automatic run_txn(input logic port_b, input logic we, input logic [18:0] addr,
                           input logic [7:0] data, output int ack_cyc, output logic [7:0] rd,
                           output logic [31:0] ce_m, output logic [31:0] we_m,
                           output logic [31:0] oe_m, output logic wrong_ack);
        if (port_b) begin
            bus.we_b = we; bus.addr_b = addr; bus.data_b = data; bus.req_b = 1'b1;
        end else begin
            bus.we_a = we; bus.addr_a = addr; bus.data_a = data; bus.req_a = 1'b1;
        end
        ack_cyc = -1; rd = 8'h00; ce_m = 0; we_m = 0; oe_m = 0; wrong_ack = 1'b0;
        for (int k = 0; k < 32 && ack_cyc < 0; k++) begin
            @(negedge clk);
            cycle_checks();
            ce_m[k] = !bus.sram_ce_n;
            we_m[k] = !bus.sram_we_n;
            oe_m[k] = !bus.sram_oe_n;
            if (port_b ? bus.ack_b : bus.ack_a) begin
                ack_cyc = k;
                rd      = bus.read_data;
            end
            if (port_b ? bus.ack_a : bus.ack_b) wrong_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
    endtask

    // Both ports request together; each drops its request after its own ack.
    task automatic run_pair(input logic [18:0] addr_a, input logic [7:0] data_a,
                            input logic [18:0] addr_b, input logic [7:0] data_b,
                            output int cyc_a, output int cyc_b);
        logic drop_a, drop_b;
        bus.we_a = 1'b1; bus.addr_a = addr_a; bus.data_a = data_a; bus.req_a = 1'b1;
        bus.we_b = 1'b1; bus.addr_b = addr_b; bus.data_b = data_b; bus.req_b = 1'b1;
        cyc_a = -1; cyc_b = -1;
        for (int k = 0; k < 48 && (cyc_a < 0 || cyc_b < 0); k++) begin
            @(negedge clk);
            cycle_checks();
            drop_a = bus.ack_a && cyc_a < 0;
            drop_b = bus.ack_b && cyc_b < 0;
            if (drop_a) cyc_a = k;
            if (drop_b) cyc_b = k;
            if (drop_a || drop_b) begin
                @(posedge clk);
                #1;
                if (drop_a) bus.req_a = 1'b0;
                if (drop_b) bus.req_b = 1'b0;
            end
        end
        if (cyc_a < 0 || cyc_b < 0) begin
            @(posedge clk);
            #1;
            bus.req_a = 1'b0;
            bus.req_b = 1'b0;
        end
    endtask

    typedef struct {
        logic        port_b;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_rd;
        int          exp_ack;
        logic [31:0] exp_ce;
        logic [31:0] exp_we;
        logic [31:0] exp_oe;
    } vec_t;

    vec_t        vecs[12];
    int          ack_cyc, cyc_a, cyc_b;
    logic [7:0]  rd;
    logic [31:0] ce_m, we_m, oe_m;
    logic        wrong;
    int          acks_seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // With ACCESS_CYCLES=2: CE low 1..4, WE low 2..3 (write), OE low 1..3 (read), ack 4.
        vecs[0]  = '{1'b0, 1'b1, 19'h00010, 8'hA5, 8'h00, 4, 32'h1E, 32'h0C, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 19'h00010, 8'h00, 8'hA5, 4, 32'h1E, 32'h00, 32'h0E};
        vecs[2]  = '{1'b0, 1'b1, 19'h00000, 8'h10, 8'h00, 4, 32'h1E, 32'h0C, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 19'h00001, 8'h11, 8'h00, 4, 32'h1E, 32'h0C, 32'h00};
        vecs[4]  = '{1'b0, 1'b1, 19'h00002, 8'h12, 8'h00, 4, 32'h1E, 32'h0C, 32'h00};
        vecs[5]  = '{1'b0, 1'b1, 19'h00003, 8'h13, 8'h00, 4, 32'h1E, 32'h0C, 32'h00};
        vecs[6]  = '{1'b0, 1'b0, 19'h00000, 8'h00, 8'h10, 4, 32'h1E, 32'h00, 32'h0E};
        vecs[7]  = '{1'b0, 1'b0, 19'h00001, 8'h00, 8'h11, 4, 32'h1E, 32'h00, 32'h0E};
        vecs[8]  = '{1'b0, 1'b0, 19'h00002, 8'h00, 8'h12, 4, 32'h1E, 32'h00, 32'h0E};
        vecs[9]  = '{1'b0, 1'b0, 19'h00003, 8'h00, 8'h13, 4, 32'h1E, 32'h00, 32'h0E};
        vecs[10] = '{1'b1, 1'b1, 19'h00030, 8'h77, 8'h00, 4, 32'h1E, 32'h0C, 32'h00};
        vecs[11] = '{1'b1, 1'b0, 19'h00030, 8'h00, 8'h77, 4, 32'h1E, 32'h00, 32'h0E};

        bus.req_a = 0; bus.we_a = 0; bus.addr_a = '0; bus.data_a = '0;
        bus.req_b = 0; bus.we_b = 0; bus.addr_b = '0; bus.data_b = '0;
        bus1.req_a = 0; bus1.we_a = 0; bus1.addr_a = '0; bus1.data_a = '0;
        bus1.req_b = 0; bus1.we_b = 0; bus1.addr_b = '0; bus1.data_b = '0;
        bus15.req_a = 0; bus15.we_a = 0; bus15.addr_a = '0; bus15.data_a = '0;
        bus15.req_b = 0; bus15.we_b = 0; bus15.addr_b = '0; bus15.data_b = '0;
        rst     = 1'b1;
        mem_clr = 1'b1;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;

        // Reset state
        check("rst_ce", 32'(bus.sram_ce_n), 32'd1);
        check("rst_we", 32'(bus.sram_we_n), 32'd1);
        check("rst_oe", 32'(bus.sram_oe_n), 32'd1);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
        check("rst_rdata", 32'(bus.read_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_drive", 32'(dut.data_oe_q), 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-port writes/readbacks, each re-raised right after the previous ack.
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].port_b, vecs[i].we, vecs[i].addr, vecs[i].data,
                    ack_cyc, rd, ce_m, we_m, oe_m, wrong);
            check($sformatf("v%0d_ack_cycle", i), 32'(ack_cyc), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_other_ack", i), 32'(wrong), 32'd0);
            check($sformatf("v%0d_ce_window", i), ce_m, vecs[i].exp_ce);
            check($sformatf("v%0d_we_window", i), we_m, vecs[i].exp_we);
            check($sformatf("v%0d_oe_window", i), oe_m, vecs[i].exp_oe);
            if (!vecs[i].we) check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
        end

        // Tie after last grant to B: A first, B five cycles later.
        run_pair(19'h1, 8'h11, 19'h2, 8'h22, cyc_a, cyc_b);
        check("pair1_a_cycle", 32'(cyc_a), 32'd4);
        check("pair1_b_cycle", 32'(cyc_b), 32'd9);
        run_txn(1'b1, 1'b0, 19'h2, 8'h00, ack_cyc, rd, ce_m, we_m, oe_m, wrong);
        check("pair1_b_readback", 32'(rd), 32'h22);
        run_txn(1'b0, 1'b0, 19'h1, 8'h00, ack_cyc, rd, ce_m, we_m, oe_m, wrong);
        check("pair1_a_readback", 32'(rd), 32'h11);
        // Last grant was A, so B wins this tie.
        run_pair(19'h4, 8'h44, 19'h5, 8'h55, cyc_a, cyc_b);
        check("pair2_b_cycle", 32'(cyc_b), 32'd4);
        check("pair2_a_cycle", 32'(cyc_a), 32'd9);

        // Reset during ACCESS of an A write (leaves the pointer favouring B).
        bus.we_a = 1'b1; bus.addr_a = 19'h20; bus.data_a = 8'h5A; bus.req_a = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_in_access", 32'(bus.sram_we_n), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ce", 32'(bus.sram_ce_n), 32'd1);
        check("abort_we", 32'(bus.sram_we_n), 32'd1);
        check("abort_oe", 32'(bus.sram_oe_n), 32'd1);
        check("abort_drive", 32'(dut.data_oe_q), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        bus.req_a = 1'b0;
        acks_seen = 0;
        repeat (3) begin
            @(negedge clk);
            acks_seen += int'(bus.ack_a) + int'(bus.ack_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            acks_seen += int'(bus.ack_a) + int'(bus.ack_b);
        end
        check("abort_no_ack", 32'(acks_seen), 32'd0);
        @(posedge clk);
        #1;
        run_pair(19'h21, 8'h66, 19'h22, 8'h67, cyc_a, cyc_b);
        check("post_rst_a_first", 32'(cyc_a), 32'd4);
        check("post_rst_b_cycle", 32'(cyc_b), 32'd9);
        run_txn(1'b0, 1'b0, 19'h20, 8'h00, ack_cyc, rd, ce_m, we_m, oe_m, wrong);
        check("abort_no_write", 32'(rd), 32'h00);

        // ACCESS_CYCLES=1: ack in cycle 3.
        bus1.we_a = 1'b1; bus1.addr_a = 19'h5; bus1.data_a = 8'h01; bus1.req_a = 1'b1;
        ack_cyc = -1;
        for (int k = 0; k < 40 && ack_cyc < 0; k++) begin
            @(negedge clk);
            if (bus1.ack_a) ack_cyc = k;
        end
        @(posedge clk);
        #1;
        bus1.req_a = 1'b0;
        check("ac1_ack_cycle", 32'(ack_cyc), 32'd3);

        // ACCESS_CYCLES=15: ack in cycle 17.
        bus15.we_a = 1'b1; bus15.addr_a = 19'h6; bus15.data_a = 8'h02; bus15.req_a = 1'b1;
        ack_cyc = -1;
        for (int k = 0; k < 40 && ack_cyc < 0; k++) begin
            @(negedge clk);
            if (bus15.ack_a) ack_cyc = k;
        end
        @(posedge clk);
        #1;
        bus15.req_a = 1'b0;
        check("ac15_ack_cycle", 32'(ack_cyc), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
